// File: rtl/sobel_stream_param_if.sv
`default_nettype none
// ============================================================================
// Module   : sobel_stream_param_if
// Purpose  : Pixel-stream bundle for sobel_stream_param (RGB in, magnitude out).
//            thresh_i exists only when SOBEL_THRESHOLD_EN is defined.
// Revision : 1.0
// ============================================================================
interface sobel_stream_param_if #(
   parameter int DATA_W = 8
);
   logic              done_i;
   logic [DATA_W-1:0] red_i;
   logic [DATA_W-1:0] green_i;
   logic [DATA_W-1:0] blue_i;
`ifdef SOBEL_THRESHOLD_EN
   logic [DATA_W-1:0] thresh_i;
`endif
   logic              ready_o;
   logic [DATA_W-1:0] red_o;
   logic [DATA_W-1:0] green_o;
   logic [DATA_W-1:0] blue_o;
   logic              done_o;
   logic              frame_done_o;

   modport master (
`ifdef SOBEL_THRESHOLD_EN
      output thresh_i,
`endif
      output done_i, red_i, green_i, blue_i,
      input  ready_o, red_o, green_o, blue_o, done_o, frame_done_o
   );

   modport slave (
`ifdef SOBEL_THRESHOLD_EN
      input  thresh_i,
`endif
      input  done_i, red_i, green_i, blue_i,
      output ready_o, red_o, green_o, blue_o, done_o, frame_done_o
   );
endinterface
`default_nettype wire

// File: rtl/sobel_stream_param.sv
`default_nettype none
// ============================================================================
// Module   : sobel_stream_param
// Purpose  : Streaming 3x3 Sobel edge magnitude with end-of-frame flush.
//            Optional threshold output stage: SOBEL_THRESHOLD_EN.
// Revision : 1.0
// ============================================================================
module sobel_stream_param #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int COL_W  = $clog2(IMG_W),
   parameter int ROW_W  = $clog2(IMG_H)
) (
   input  wire logic           clk,
   input  wire logic           rst,
   sobel_stream_param_if.slave bus
);
   localparam int                c_GW         = DATA_W + 4;
   localparam logic [DATA_W-1:0] c_MAX        = '1;
   localparam logic [DATA_W+7:0] c_KR         = (DATA_W+8)'(77);
   localparam logic [DATA_W+7:0] c_KG         = (DATA_W+8)'(150);
   localparam logic [DATA_W+7:0] c_KB         = (DATA_W+8)'(29);
   localparam logic [COL_W:0]    c_FILL_DONE  = (COL_W+1)'(IMG_W + 1);
   localparam logic [COL_W:0]    c_FLUSH_LAST = (COL_W+1)'(IMG_W);
   localparam logic [COL_W-1:0]  c_COL_LAST   = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  c_ROW_LAST   = ROW_W'(IMG_H - 1);

   typedef enum logic [0:0] {ST_IDLE_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t            r_state;
   logic              r_ready;
   logic [COL_W-1:0]  r_in_col;
   logic [ROW_W-1:0]  r_in_row;
   logic [COL_W:0]    r_flush_cnt;
   logic [COL_W:0]    r_fill;
   logic [COL_W-1:0]  r_ccol;
   logic [ROW_W-1:0]  r_crow;

   logic              r_s1_valid, r_s1_emit, r_s1_border, r_s1_last;
   logic [DATA_W-1:0] r_s1_gray;
   logic [COL_W-1:0]  r_s1_col;

   logic [DATA_W-1:0] r_lb0 [IMG_W];
   logic [DATA_W-1:0] r_lb1 [IMG_W];
   logic [DATA_W-1:0] r_win [3][3];

   logic                    r_s2_valid, r_s2_border, r_s2_last;
   logic                    r_s3_valid, r_s3_last;
   logic signed [c_GW-1:0]  r_gx, r_gy;
   logic [DATA_W-1:0]       r_mag;
   logic                    r_done, r_fdone;

   logic                    w_push;
   logic [DATA_W+7:0]       w_luma_sum;
   logic [DATA_W-1:0]       w_gray;
   logic signed [c_GW-1:0]  w_gx, w_gy;
   logic [c_GW-1:0]         w_abs_x, w_abs_y, w_sum;
   logic [DATA_W-1:0]       w_sat, w_out;

   function automatic logic signed [c_GW-1:0] f_ext(input logic [DATA_W-1:0] p);
      f_ext = $signed({4'b0000, p});
   endfunction

   assign w_push     = (r_state == ST_IDLE_RUN && bus.done_i) || (r_state == ST_FLUSH);
   assign w_luma_sum = ({8'd0, bus.red_i} * c_KR) + ({8'd0, bus.green_i} * c_KG)
                     + ({8'd0, bus.blue_i} * c_KB);
   assign w_gray     = DATA_W'(w_luma_sum >> 8);

   // Stream position, centre tracking and flush sequencing. The first IMG_W+1
   // pushes of a frame only prime the window; every later push emits a centre.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE_RUN;
         r_ready     <= 1'b1;
         r_in_col    <= '0;
         r_in_row    <= '0;
         r_flush_cnt <= '0;
         r_fill      <= '0;
         r_ccol      <= '0;
         r_crow      <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_emit   <= 1'b0;
         r_s1_border <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s1_gray   <= '0;
         r_s1_col    <= '0;
      end else begin
         r_s1_valid <= w_push;
         if (w_push) begin
            r_s1_gray <= (r_state == ST_FLUSH) ? '0 : w_gray;
            r_s1_col  <= r_in_col;
            r_in_col  <= (r_in_col == c_COL_LAST) ? '0 : r_in_col + COL_W'(1);
            if (r_fill != c_FILL_DONE) begin
               r_fill      <= r_fill + (COL_W+1)'(1);
               r_s1_emit   <= 1'b0;
               r_s1_border <= 1'b0;
               r_s1_last   <= 1'b0;
            end else begin
               r_s1_emit   <= 1'b1;
               r_s1_border <= (r_crow == '0) || (r_crow == c_ROW_LAST)
                           || (r_ccol == '0) || (r_ccol == c_COL_LAST);
               r_s1_last   <= (r_crow == c_ROW_LAST) && (r_ccol == c_COL_LAST);
               if (r_ccol == c_COL_LAST) begin
                  r_ccol <= '0;
                  r_crow <= (r_crow == c_ROW_LAST) ? '0 : r_crow + ROW_W'(1);
               end else begin
                  r_ccol <= r_ccol + COL_W'(1);
               end
            end
         end
         case (r_state)
            ST_IDLE_RUN: begin
               if (w_push && r_in_col == c_COL_LAST) begin
                  if (r_in_row == c_ROW_LAST) begin
                     r_state     <= ST_FLUSH;
                     r_ready     <= 1'b0;
                     r_flush_cnt <= '0;
                     r_in_row    <= '0;
                  end else begin
                     r_in_row <= r_in_row + ROW_W'(1);
                  end
               end
            end
            ST_FLUSH: begin
               if (r_flush_cnt == c_FLUSH_LAST) begin
                  r_state  <= ST_IDLE_RUN;
                  r_ready  <= 1'b1;
                  r_in_col <= '0;
                  r_fill   <= '0;
                  r_ccol   <= '0;
                  r_crow   <= '0;
               end else begin
                  r_flush_cnt <= r_flush_cnt + (COL_W+1)'(1);
               end
            end
            default: r_state <= ST_IDLE_RUN;
         endcase
      end
   end

   // Line buffers and window hold data only; stale contents reach border centres alone.
   always_ff @(posedge clk) begin
      if (r_s1_valid) begin
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= r_win[r][1];
            r_win[r][1] <= r_win[r][2];
         end
         r_win[0][2]     <= r_lb0[r_s1_col];
         r_win[1][2]     <= r_lb1[r_s1_col];
         r_win[2][2]     <= r_s1_gray;
         r_lb0[r_s1_col] <= r_lb1[r_s1_col];
         r_lb1[r_s1_col] <= r_s1_gray;
      end
   end

   assign w_gx = (f_ext(r_win[0][2]) + (f_ext(r_win[1][2]) <<< 1) + f_ext(r_win[2][2]))
               - (f_ext(r_win[0][0]) + (f_ext(r_win[1][0]) <<< 1) + f_ext(r_win[2][0]));
   assign w_gy = (f_ext(r_win[2][0]) + (f_ext(r_win[2][1]) <<< 1) + f_ext(r_win[2][2]))
               - (f_ext(r_win[0][0]) + (f_ext(r_win[0][1]) <<< 1) + f_ext(r_win[0][2]));

   assign w_abs_x = r_gx[c_GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
   assign w_abs_y = r_gy[c_GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
   assign w_sum   = w_abs_x + w_abs_y;
   assign w_sat   = (|w_sum[c_GW-1:DATA_W]) ? c_MAX : w_sum[DATA_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
   assign w_out   = (w_sat >= bus.thresh_i) ? c_MAX : '0;
`else
   assign w_out   = w_sat;
`endif

   // Border centres enter stage 4 with zero gradient so the threshold sees mag 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_border <= 1'b0;
         r_s2_last   <= 1'b0;
         r_s3_valid  <= 1'b0;
         r_s3_last   <= 1'b0;
         r_gx        <= '0;
         r_gy        <= '0;
         r_mag       <= '0;
         r_done      <= 1'b0;
         r_fdone     <= 1'b0;
      end else begin
         r_s2_valid  <= r_s1_valid & r_s1_emit;
         r_s2_border <= r_s1_border;
         r_s2_last   <= r_s1_last;
         r_s3_valid  <= r_s2_valid;
         r_s3_last   <= r_s2_valid & r_s2_last;
         r_gx        <= r_s2_border ? '0 : w_gx;
         r_gy        <= r_s2_border ? '0 : w_gy;
         r_done      <= r_s3_valid;
         r_fdone     <= r_s3_valid & r_s3_last;
         r_mag       <= r_s3_valid ? w_out : '0;
      end
   end

   assign bus.ready_o      = r_ready;
   assign bus.red_o        = r_mag;
   assign bus.green_o      = r_mag;
   assign bus.blue_o       = r_mag;
   assign bus.done_o       = r_done;
   assign bus.frame_done_o = r_fdone;
endmodule
`default_nettype wire
